stack_exec: RTL

- Execute/sequencer stage that sits directly upstream of the data stack.
- Accepts decoded stack instructions over a valid/ready handshake and reads the top-of-stack outputs (r0out, r1out).
- Computes results and drives the stack's cs/mode/dsel/r0in/r1in for exactly one cycle per instruction.
- Tracks stack depth, blocks instructions that would over- or underflow, and sequences multi-cycle MUL.

---
 rtl/stack_exec_if.sv | 35 +++
 rtl/stack_exec.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_exec_if.sv
// stack_exec_if: instruction handshake plus data-stack control/readback bus
// for the stack_exec stage. The master side issues instructions and supplies
// the stack read ports; the slave side (stack_exec) drives the stack controls.
interface stack_exec_if #(
  parameter int W  = 16,
  parameter int DW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_imm;
  logic [W-1:0]  st_r0out;
  logic [W-1:0]  st_r1out;
  logic          st_cs;
  logic [2:0]    st_mode;
  logic [2:0]    st_dsel;
  logic [W-1:0]  st_r0in;
  logic [W-1:0]  st_r1in;
  logic [DW-1:0] depth;
  logic          err;
  logic [1:0]    err_code;
  logic          err_clr;

  modport master (
    output in_valid, in_op, in_imm, st_r0out, st_r1out, err_clr,
    input  in_ready, st_cs, st_mode, st_dsel, st_r0in, st_r1in,
           depth, err, err_code
  );

  modport slave (
    input  in_valid, in_op, in_imm, st_r0out, st_r1out, err_clr,
    output in_ready, st_cs, st_mode, st_dsel, st_r0in, st_r1in,
           depth, err, err_code
  );
endinterface

// File: rtl/stack_exec.sv
// stack_exec: execute/sequencer stage in front of the data stack.
// Single-cycle ops write the stack combinationally in their accept cycle;
// MUL (optional, macro STACK_EXEC_MUL_EN) runs a W-step shift-add and writes
// back one cycle later. Depth is tracked here so over/underflow is blocked
// before the stack sees a write.
//
// state | meaning
// IDLE  | ready for an instruction, single-cycle ops issue here
// MUL   | one shift-add step per cycle, W cycles
// WB    | POPREP of the product, then back to IDLE
module stack_exec #(
  parameter int W  = 16,
  parameter int D  = 16,
  parameter int DW = 5
) (
  input logic        clk,
  input logic        rst,
  stack_exec_if.slave bus
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_DROP  = 4'd2;
  localparam logic [3:0] OP_DUP   = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_PICK  = 4'd11;

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_PUSH   = 3'd1;
  localparam logic [2:0] MODE_POP    = 3'd2;
  localparam logic [2:0] MODE_REP2   = 3'd4;
  localparam logic [2:0] MODE_POPREP = 3'd5;

  localparam logic [1:0] ERR_UNF = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  localparam logic [DW-1:0] DEP_MAX = DW'(D);
  localparam logic [DW-1:0] DEP_ONE = DW'(1);
  localparam logic [DW-1:0] DEP_TWO = DW'(2);

  logic [DW-1:0] depth_q, depth_nxt;
  logic          err_q;
  logic [1:0]    code_q;

  logic          is_idle;
  logic          accept;
  logic          fault;
  logic [1:0]    fault_code;
  logic          cs_c;
  logic [2:0]    mode_c;
  logic [2:0]    dsel_c;
  logic [W-1:0]  r0_c, r1_c;
  logic [W-1:0]  alu;
  logic [DW-1:0] pick_idx;
  logic          mul_start;

`ifdef STACK_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int         CW     = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]    state_q;
  logic [CW-1:0] mul_cnt;
  logic [W-1:0]  mul_a, mul_b, mul_acc;

  assign is_idle = (state_q == S_IDLE);
`else
  assign is_idle = 1'b1;
`endif

  assign bus.in_ready = rst & is_idle;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pick_idx     = DW'(bus.in_imm[2:0]);

  // Two-operand ALU result, T1 op T0 modulo 2^W
  always_comb begin
    alu = '0;
    case (bus.in_op)
      OP_ADD:  alu = bus.st_r1out + bus.st_r0out;
      OP_SUB:  alu = bus.st_r1out - bus.st_r0out;
      OP_AND:  alu = bus.st_r1out & bus.st_r0out;
      OP_OR:   alu = bus.st_r1out | bus.st_r0out;
      OP_XOR:  alu = bus.st_r1out ^ bus.st_r0out;
      default: alu = '0;
    endcase
  end

  // Instruction decode, depth checks and stack control for the current cycle
  always_comb begin
    cs_c       = 1'b0;
    mode_c     = MODE_NONE;
    r0_c       = '0;
    r1_c       = '0;
    dsel_c     = 3'd1;
    fault      = 1'b0;
    fault_code = 2'd0;
    depth_nxt  = depth_q;
    mul_start  = 1'b0;

    // PICK steers the stack read port before acceptance so T1 is valid
    if (is_idle && bus.in_op == OP_PICK) dsel_c = bus.in_imm[2:0];

    if (accept) begin
      case (bus.in_op)
        OP_NOP: ;
        OP_PUSHI: begin
          if (depth_q >= DEP_MAX) begin
            fault = 1'b1; fault_code = ERR_OVF;
          end else begin
            cs_c = 1'b1; mode_c = MODE_PUSH; r0_c = bus.in_imm;
            depth_nxt = depth_q + DEP_ONE;
          end
        end
        OP_DROP: begin
          if (depth_q < DEP_ONE) begin
            fault = 1'b1; fault_code = ERR_UNF;
          end else begin
            cs_c = 1'b1; mode_c = MODE_POP;
            depth_nxt = depth_q - DEP_ONE;
          end
        end
        OP_DUP: begin
          if (depth_q < DEP_ONE) begin
            fault = 1'b1; fault_code = ERR_UNF;
          end else if (depth_q >= DEP_MAX) begin
            fault = 1'b1; fault_code = ERR_OVF;
          end else begin
            cs_c = 1'b1; mode_c = MODE_PUSH; r0_c = bus.st_r0out;
            depth_nxt = depth_q + DEP_ONE;
          end
        end
        OP_SWAP: begin
          if (depth_q < DEP_TWO) begin
            fault = 1'b1; fault_code = ERR_UNF;
          end else begin
            cs_c = 1'b1; mode_c = MODE_REP2;
            r0_c = bus.st_r1out; r1_c = bus.st_r0out;
          end
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          if (depth_q < DEP_TWO) begin
            fault = 1'b1; fault_code = ERR_UNF;
          end else begin
            cs_c = 1'b1; mode_c = MODE_POPREP; r0_c = alu;
            depth_nxt = depth_q - DEP_ONE;
          end
        end
`ifdef STACK_EXEC_MUL_EN
        OP_MUL: begin
          if (depth_q < DEP_TWO) begin
            fault = 1'b1; fault_code = ERR_UNF;
          end else begin
            mul_start = 1'b1;
          end
        end
`endif
        OP_PICK: begin
          if (depth_q <= pick_idx) begin
            fault = 1'b1; fault_code = ERR_UNF;
          end else if (depth_q >= DEP_MAX) begin
            fault = 1'b1; fault_code = ERR_OVF;
          end else begin
            cs_c = 1'b1; mode_c = MODE_PUSH; r0_c = bus.st_r1out;
            depth_nxt = depth_q + DEP_ONE;
          end
        end
        default: begin
          fault = 1'b1; fault_code = ERR_ILL;
        end
      endcase
    end

`ifdef STACK_EXEC_MUL_EN
    if (state_q == S_WB) begin
      cs_c = 1'b1; mode_c = MODE_POPREP; r0_c = mul_acc;
      depth_nxt = depth_q - DEP_ONE;
    end
`endif

    // Reset masks every stack write, including an in-flight writeback
    if (!rst) begin
      cs_c   = 1'b0;
      mode_c = MODE_NONE;
      r0_c   = '0;
      r1_c   = '0;
    end
  end

  assign bus.st_cs    = cs_c;
  assign bus.st_mode  = mode_c;
  assign bus.st_dsel  = dsel_c;
  assign bus.st_r0in  = r0_c;
  assign bus.st_r1in  = r1_c;
  assign bus.depth    = depth_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;

  // Depth tracking and sticky fault register; the first code stays until cleared
  always_ff @(posedge clk) begin
    if (!rst) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      depth_q <= depth_nxt;
      if (fault) begin
        err_q <= 1'b1;
        if (!err_q || bus.err_clr) code_q <= fault_code;
      end else if (bus.err_clr) begin
        err_q  <= 1'b0;
        code_q <= 2'd0;
      end
    end
  end

`ifdef STACK_EXEC_MUL_EN
  // Multiplier sequencer: W shift-add steps keeping only the low W product bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mul_cnt <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            mul_a   <= bus.st_r1out;
            mul_b   <= bus.st_r0out;
            mul_acc <= '0;
            mul_cnt <= CW'(W - 1);
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt - CW'(1);
          if (mul_cnt == '0) state_q <= S_WB;
        end
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`endif

endmodule
